// File: rtl/pci_bridge_pkg.sv
// Shared types for the PCI bridge transaction collector: record layout, status codes,
// bus command codes and the phase-tracker state encoding.
package pci_bridge_pkg;

  typedef enum logic [1:0] {
    REC_OK           = 2'd0,
    REC_RETRY        = 2'd1,
    REC_DISCONNECT   = 2'd2,
    REC_MASTER_ABORT = 2'd3
  } pci_rec_status_e;

  typedef struct packed {
    logic [31:0]     addr;
    logic [3:0]      cmd;
    logic [31:0]     data;
    logic [3:0]      be;
    logic            last;
    pci_rec_status_e status;
    logic            perr;
  } pci_beat_rec_t;

  localparam logic [3:0] MEM_RD = 4'h6;
  localparam logic [3:0] MEM_WR = 4'h7;
  localparam logic [3:0] CFG_RD = 4'hA;
  localparam logic [3:0] CFG_WR = 4'hB;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEVSEL_WAIT,
    S_DATA,
    S_TURN
  } pci_txn_state_e;

  function automatic logic even_par(input logic [31:0] ad, input logic [3:0] cbe);
    return ^{ad, cbe};
  endfunction

endpackage

// File: rtl/pci_bridge_pci_txn_collector_if.sv
// Sampled PCI bus lines plus the outgoing beat-record stream.
// master: bus/consumer side; slave: the collector.
interface pci_bridge_pci_txn_collector_if;
  logic [31:0] AD;
  logic [3:0]  CBE;
  logic        FRAME;
  logic        IRDY;
  logic        TRDY;
  logic        DEVSEL;
  logic        STOP;
  logic        PAR;
  logic        rec_valid;
  logic        rec_ready;
  logic [31:0] rec_addr;
  logic [3:0]  rec_cmd;
  logic [31:0] rec_data;
  logic [3:0]  rec_be;
  logic        rec_last;
  logic [1:0]  rec_status;
  logic        rec_perr;

  modport master (
    output AD, CBE, FRAME, IRDY, TRDY, DEVSEL, STOP, PAR, rec_ready,
    input  rec_valid, rec_addr, rec_cmd, rec_data, rec_be, rec_last, rec_status, rec_perr
  );

  modport slave (
    input  AD, CBE, FRAME, IRDY, TRDY, DEVSEL, STOP, PAR, rec_ready,
    output rec_valid, rec_addr, rec_cmd, rec_data, rec_be, rec_last, rec_status, rec_perr
  );
endinterface

// File: rtl/pci_bridge_rec_fifo.sv
// Synchronous FIFO of beat records; head is presented from storage and zeroed when empty.
module pci_bridge_rec_fifo
  import pci_bridge_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  pci_beat_rec_t push_rec,
  input  logic          pop,
  output pci_beat_rec_t head_rec,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  pci_beat_rec_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wr_en, rd_en;

  // A push into a full FIFO is accepted when the head leaves in the same clock.
  always_comb begin
    full     = (cnt_q == (AW+1)'(DEPTH));
    empty    = (cnt_q == '0);
    rd_en    = pop & ~empty;
    wr_en    = push & (~full | rd_en);
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    head_rec = empty ? '0 : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_ptr_q] <= push_rec;
  end
endmodule

// File: rtl/pci_bridge_pci_txn_collector.sv
// PCI bus-phase tracker emitting one record per data beat through a buffered stream.
// Optional parity checking: define PCI_BRIDGE_PARITY_CHECK_EN (adds one clock of push latency).
module pci_bridge_pci_txn_collector
  import pci_bridge_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int DEVSEL_TIMEOUT = 5,
  parameter int CNT_W          = 16
) (
  input  logic                            clk,
  input  logic                            RST,
  pci_bridge_pci_txn_collector_if.slave   bus,
  output logic [CNT_W-1:0]                beat_cnt,
  output logic [CNT_W-1:0]                ovf_cnt,
  output logic                            busy
);
  localparam int TMO_W = $clog2(DEVSEL_TIMEOUT + 1);

  pci_txn_state_e   state_q, state_d;
  logic             prev_frame_q, prev_frame_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             seen_q, seen_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic             addr_phase, data_eval, xfer, new_push;
  pci_beat_rec_t    new_rec, fifo_rec, head_rec;
  logic             fifo_push, full, empty, pop;

  always_comb begin
    state_d      = state_q;
    prev_frame_d = bus.FRAME;
    addr_d       = addr_q;
    cmd_d        = cmd_q;
    tmo_d        = tmo_q;
    seen_d       = seen_q;
    beat_cnt_d   = beat_cnt_q;
    addr_phase   = 1'b0;
    data_eval    = 1'b0;
    xfer         = ~bus.IRDY & ~bus.TRDY;
    new_push     = 1'b0;
    new_rec      = '0;
    case (state_q)
      S_IDLE: begin
        if (!bus.FRAME && prev_frame_q) begin
          addr_phase = 1'b1;
          addr_d     = bus.AD;
          cmd_d      = bus.CBE;
          tmo_d      = TMO_W'(DEVSEL_TIMEOUT);
          seen_d     = 1'b0;
          state_d    = S_DEVSEL_WAIT;
        end
      end
      S_DEVSEL_WAIT: begin
        // DEVSEL# on this clock means it is already a data clock (fast decode).
        if (!bus.DEVSEL) begin
          state_d   = S_DATA;
          data_eval = 1'b1;
        end else if (tmo_q <= TMO_W'(1)) begin
          new_push       = 1'b1;
          new_rec.addr   = addr_q;
          new_rec.cmd    = cmd_q;
          new_rec.last   = 1'b1;
          new_rec.status = REC_MASTER_ABORT;
          state_d        = S_TURN;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      S_DATA:  data_eval = 1'b1;
      S_TURN:  if (bus.FRAME && bus.IRDY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (data_eval) begin
      if (xfer) begin
        new_push       = 1'b1;
        new_rec.addr   = addr_q;
        new_rec.cmd    = cmd_q;
        new_rec.data   = bus.AD;
        new_rec.be     = ~bus.CBE;
        new_rec.last   = bus.FRAME | ~bus.STOP;
        new_rec.status = bus.STOP ? REC_OK : REC_DISCONNECT;
        addr_d         = addr_q + 32'd4;
        beat_cnt_d     = beat_cnt_q + CNT_W'(1);
        seen_d         = 1'b1;
        if (bus.FRAME || !bus.STOP) state_d = S_TURN;
      end else if (!bus.STOP && !bus.IRDY) begin
        new_push       = 1'b1;
        new_rec.addr   = addr_q;
        new_rec.cmd    = cmd_q;
        new_rec.last   = 1'b1;
        new_rec.status = seen_q ? REC_DISCONNECT : REC_RETRY;
        state_d        = S_TURN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= S_IDLE;
      prev_frame_q <= 1'b1;
      addr_q       <= '0;
      cmd_q        <= '0;
      tmo_q        <= '0;
      seen_q       <= 1'b0;
      beat_cnt_q   <= '0;
      ovf_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      prev_frame_q <= prev_frame_d;
      addr_q       <= addr_d;
      cmd_q        <= cmd_d;
      tmo_q        <= tmo_d;
      seen_q       <= seen_d;
      beat_cnt_q   <= beat_cnt_d;
      ovf_cnt_q    <= ovf_cnt_d;
    end
  end

`ifdef PCI_BRIDGE_PARITY_CHECK_EN
  // Records wait one clock in a pending slot so PAR for their phase can be folded in.
  logic          pend_valid_q, pend_valid_d;
  pci_beat_rec_t pend_rec_q, pend_rec_d;
  logic          pend_chk_q, pend_chk_d;
  logic          pend_par_q, pend_par_d;
  logic          addr_chk_q, addr_chk_d;
  logic          addr_par_q, addr_par_d;
  logic          addr_perr_q, addr_perr_d;

  always_comb begin
    pend_valid_d = new_push;
    pend_rec_d   = new_rec;
    pend_chk_d   = data_eval & xfer;
    pend_par_d   = even_par(bus.AD, bus.CBE);
    addr_chk_d   = addr_phase;
    addr_par_d   = addr_phase ? even_par(bus.AD, bus.CBE) : addr_par_q;
    addr_perr_d  = addr_phase ? 1'b0 : (addr_perr_q | (addr_chk_q & (bus.PAR != addr_par_q)));
    fifo_push    = pend_valid_q;
    fifo_rec     = pend_rec_q;
    fifo_rec.perr = addr_perr_q | (pend_chk_q & (bus.PAR != pend_par_q));
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      pend_valid_q <= 1'b0;
      pend_rec_q   <= '0;
      pend_chk_q   <= 1'b0;
      pend_par_q   <= 1'b0;
      addr_chk_q   <= 1'b0;
      addr_par_q   <= 1'b0;
      addr_perr_q  <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_rec_q   <= pend_rec_d;
      pend_chk_q   <= pend_chk_d;
      pend_par_q   <= pend_par_d;
      addr_chk_q   <= addr_chk_d;
      addr_par_q   <= addr_par_d;
      addr_perr_q  <= addr_perr_d;
    end
  end
`else
  always_comb begin
    fifo_push = new_push;
    fifo_rec  = new_rec;
  end
`endif

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (fifo_push && full && !pop && !(&ovf_cnt_q)) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
  end

  assign pop = ~empty & bus.rec_ready;

  pci_bridge_rec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (RST),
    .push     (fifo_push),
    .push_rec (fifo_rec),
    .pop      (pop),
    .head_rec (head_rec),
    .full     (full),
    .empty    (empty)
  );

  assign bus.rec_valid  = ~empty;
  assign bus.rec_addr   = head_rec.addr;
  assign bus.rec_cmd    = head_rec.cmd;
  assign bus.rec_data   = head_rec.data;
  assign bus.rec_be     = head_rec.be;
  assign bus.rec_last   = head_rec.last;
  assign bus.rec_status = head_rec.status;
  assign bus.rec_perr   = head_rec.perr;
  assign beat_cnt       = beat_cnt_q;
  assign ovf_cnt        = ovf_cnt_q;
  assign busy           = (state_q != S_IDLE);
endmodule

// File: tb/tb_pci_bridge_pci_txn_collector.sv
// Directed bench for the PCI transaction collector with a record scoreboard queue.
module tb_pci_bridge_pci_txn_collector;
  import pci_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        RST;
  logic [15:0] beat_cnt, ovf_cnt;
  logic        busy;
  logic        par_flip = 1'b0;
  int          n_chk = 0, n_pass = 0, n_fail = 0;
  int          exp_beats = 0;
  pci_beat_rec_t exp_q[$];
  pci_beat_rec_t got_r, exp_r;

  pci_bridge_pci_txn_collector_if bus();

  pci_bridge_pci_txn_collector dut (
    .clk      (clk),
    .RST      (RST),
    .bus      (bus),
    .beat_cnt (beat_cnt),
    .ovf_cnt  (ovf_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // PAR for the phase that just ended is presented on the following clock.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.PAR  = (^{bus.AD, bus.CBE}) ^ par_flip;
    par_flip = 1'b0;
  endtask

  task automatic idle_bus();
    bus.FRAME = 1'b1; bus.IRDY = 1'b1; bus.TRDY = 1'b1;
    bus.DEVSEL = 1'b1; bus.STOP = 1'b1;
    bus.AD = '0; bus.CBE = '0;
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) tick();
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // stop_at: beat index carrying STOP#; stop_data selects disconnect-with-data vs retry-style stop.
  task automatic burst(input logic [31:0] addr, input logic [3:0] cmd, input int nb,
                       input int stop_at, input bit stop_data,
                       input logic [31:0] dbase, input logic [3:0] cbase, input int flip_at);
    pci_beat_rec_t e;
    bit brk;
    bus.FRAME = 1'b0; bus.AD = addr; bus.CBE = cmd;
    tick();
    for (int i = 0; i < nb; i++) begin
      brk = (i == stop_at);
      bus.DEVSEL = 1'b0;
      bus.IRDY   = 1'b0;
      bus.TRDY   = brk && !stop_data;
      bus.STOP   = !brk;
      bus.FRAME  = (i == nb - 1);
      bus.AD     = dbase + 32'(i);
      bus.CBE    = cbase + 4'(i);
      e.addr = addr + 32'(4 * i);
      e.cmd  = cmd;
      e.perr = 1'b0;
      if (brk && !stop_data) begin
        e.data   = '0;
        e.be     = '0;
        e.last   = 1'b1;
        e.status = (i == 0) ? REC_RETRY : REC_DISCONNECT;
      end else begin
        e.data   = bus.AD;
        e.be     = ~bus.CBE;
        e.last   = (i == nb - 1) || brk;
        e.status = brk ? REC_DISCONNECT : REC_OK;
`ifdef PCI_BRIDGE_PARITY_CHECK_EN
        e.perr   = (i == flip_at);
`endif
        exp_beats++;
      end
      exp_q.push_back(e);
      par_flip = (i == flip_at);
      tick();
      if (brk) break;
    end
    idle_bus();
    tick();
    tick();
  endtask

  always @(negedge clk) begin
    if (!RST && bus.rec_valid && bus.rec_ready) begin
      got_r.addr   = bus.rec_addr;
      got_r.cmd    = bus.rec_cmd;
      got_r.data   = bus.rec_data;
      got_r.be     = bus.rec_be;
      got_r.last   = bus.rec_last;
      got_r.status = pci_rec_status_e'(bus.rec_status);
      got_r.perr   = bus.rec_perr;
      n_chk++;
      assert (exp_q.size() != 0) n_pass++;
      else begin
        n_fail++;
        $error("FAIL unexpected_rec: got %h expected none", got_r);
      end
      if (exp_q.size() != 0) begin
        exp_r = exp_q.pop_front();
        n_chk++;
        assert (got_r === exp_r) n_pass++;
        else begin
          n_fail++;
          $error("FAIL record: got %h expected %h", got_r, exp_r);
        end
      end
    end
  end

  initial begin
    RST = 1'b1;
    bus.rec_ready = 1'b0;
    bus.PAR = 1'b0;
    idle_bus();
    tick(); tick(); tick();
    @(negedge clk);
    chk("rst_valid", 64'(bus.rec_valid), 64'd0);
    chk("rst_addr", 64'(bus.rec_addr), 64'd0);
    chk("rst_beat", 64'(beat_cnt), 64'd0);
    chk("rst_ovf", 64'(ovf_cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    tick();
    RST = 1'b0;
    tick();

    // single write beat
    bus.rec_ready = 1'b1;
    burst(32'h1000_0000, MEM_WR, 1, -1, 1'b0, 32'hDEAD_BEEF, 4'h0, -1);
    wait_drain("t1_drain");
    chk("t1_beat", 64'(beat_cnt), 64'd1);

    // 4-beat read across 0x1000 with consumer stalled
    bus.rec_ready = 1'b0;
    burst(32'h0000_0FF8, MEM_RD, 4, -1, 1'b0, 32'h1111_0000, 4'h3, -1);
    tick(); tick();
    @(negedge clk);
    chk("t2_valid", 64'(bus.rec_valid), 64'd1);
    chk("t2_head_addr", 64'(bus.rec_addr), 64'h0FF8);
    chk("t2_head_last", 64'(bus.rec_last), 64'd0);
    tick();
    bus.rec_ready = 1'b1;
    wait_drain("t2_drain");
    chk("t2_beat", 64'(beat_cnt), 64'd5);

    // master abort
    exp_q.push_back('{addr: 32'h2000_0000, cmd: MEM_RD, data: 32'h0, be: 4'h0,
                      last: 1'b1, status: REC_MASTER_ABORT, perr: 1'b0});
    bus.FRAME = 1'b0; bus.AD = 32'h2000_0000; bus.CBE = MEM_RD;
    tick();
    bus.FRAME = 1'b1; bus.IRDY = 1'b0; bus.AD = '0; bus.CBE = '0;
    tick(); tick();
    @(negedge clk);
    chk("t3_busy_wait", 64'(busy), 64'd1);
    for (int k = 0; k < 6; k++) tick();
    bus.IRDY = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("t3_busy_idle", 64'(busy), 64'd0);
    wait_drain("t3_drain");
    chk("t3_beat", 64'(beat_cnt), 64'd5);

    // retry, disconnect with data, disconnect without data
    burst(32'h3000_0000, MEM_WR, 1, 0, 1'b0, 32'h5555_0000, 4'h0, -1);
    burst(32'h3000_0100, MEM_WR, 2, 1, 1'b1, 32'h6666_0000, 4'h1, -1);
    burst(32'h3000_0200, CFG_RD, 3, 2, 1'b0, 32'h7777_0000, 4'h2, -1);
    wait_drain("t4_drain");
    chk("t4_beat", 64'(beat_cnt), 64'(exp_beats));

    // overflow: 10 beats into an 8-deep FIFO with no consumer
    bus.rec_ready = 1'b0;
    burst(32'h4000_0000, MEM_WR, 10, -1, 1'b0, 32'h8888_0000, 4'h0, -1);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    tick();
    @(negedge clk);
    chk("t5_ovf", 64'(ovf_cnt), 64'd2);
    chk("t5_beat", 64'(beat_cnt), 64'(exp_beats));
    tick();
    bus.rec_ready = 1'b1;
    wait_drain("t5_drain");

    // reset in the middle of a burst
    bus.rec_ready = 1'b0;
    bus.FRAME = 1'b0; bus.AD = 32'h5000_0000; bus.CBE = MEM_WR;
    tick();
    bus.DEVSEL = 1'b0; bus.IRDY = 1'b0; bus.TRDY = 1'b0; bus.AD = 32'hAAAA_0001;
    tick();
    bus.AD = 32'hAAAA_0002;
    tick();
    @(negedge clk);
    chk("t5_busy_mid", 64'(busy), 64'd1);
    RST = 1'b1;
    idle_bus();
    tick();
    @(negedge clk);
    chk("t5_rst_valid", 64'(bus.rec_valid), 64'd0);
    chk("t5_rst_beat", 64'(beat_cnt), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_ovf", 64'(ovf_cnt), 64'd0);
    exp_beats = 0;
    tick();
    RST = 1'b0;
    tick();

    // parity flip on the second of three beats
    bus.rec_ready = 1'b1;
    burst(32'h6000_0000, MEM_WR, 3, -1, 1'b0, 32'h1234_5678, 4'h4, 1);
    wait_drain("t6_drain");
    chk("t6_beat", 64'(beat_cnt), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
